// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - fixed-latency 128-bit line backing store for the L2 memory port
// Optional checker: define MEM_RESP_PROTO_CHK_EN to build the sticky proto_err flag.
module mem_line_responder #(
  parameter int ADDR_W     = 28,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 8
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              proto_err
);

  localparam int CNT_W = 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  op_q, op_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [LINE_W-1:0]     rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  mem_we;

  logic [LINE_W-1:0]     mem_array [DEPTH];

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  unused_addr_hi;

  assign req_idx        = mem_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read ^ mem_write) begin
          op_d    = mem_write;
          idx_d   = req_idx;
          wdata_d = mem_wdata;
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          ready_d = 1'b1;
          state_d = S_DONE;
          if (op_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_array[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // The cache still holds the finished request here; never re-accept it.
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  // Storage is deliberately unreset so line contents survive proc_reset_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[idx_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;

`ifdef MEM_RESP_PROTO_CHK_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (mem_read && mem_write) begin
      perr_d = 1'b1;
    end
    if ((state_q == S_BUSY) && (mem_read || mem_write) &&
        ((mem_write != op_q) || (req_idx != idx_q))) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - directed self-checking bench for mem_line_responder
module tb_mem_line_responder;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;
  localparam int LAT    = 8;
`ifdef MEM_RESP_PROTO_CHK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic              clk;
  logic              proc_reset_n;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              proto_err;

  int n_checks;
  int n_pass;

  mem_line_responder #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH_LOG2(10), .LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .proto_err    (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the bus idle; leaves the request dropped one cycle after ready.
  task automatic access(input logic wr, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wd,
                        output int lat, output logic [LINE_W-1:0] rd);
    int cyc;
    cyc       = 0;
    mem_write = wr;
    mem_read  = !wr;
    mem_addr  = addr;
    mem_wdata = wd;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!mem_ready && cyc < 60);
    lat = cyc - 1;
    rd  = mem_rdata;
    @(negedge clk);
    chk("ready_one_cycle", {127'd0, mem_ready}, '0);
    if (!wr) chk("rdata_hold", mem_rdata, rd);
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  logic [LINE_W-1:0] d_a5, d3, d10, d4, d7, dx, rd, last_rd;
  int lat, pulses;

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    proc_reset_n = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    d_a5 = {16{8'hA5}};
    d3   = {4{32'h3333_0003}};
    d10  = {4{32'h1010_0010}};
    d4   = {4{32'h4040_0400}};
    d7   = {4{32'h7777_0007}};
    dx   = {4{32'hDEAD_BEEF}};

    repeat (3) @(negedge clk);
    chk("rst_ready", {127'd0, mem_ready}, '0);
    chk("rst_rdata", mem_rdata, '0);
    chk("rst_perr", {127'd0, proto_err}, '0);
    proc_reset_n = 1'b1;
    @(negedge clk);

    access(1'b1, 28'h5, d_a5, lat, rd);
    chk("wr5_latency", 128'(lat), 128'(LAT));
    access(1'b0, 28'h5, '0, lat, rd);
    chk("rd5_latency", 128'(lat), 128'(LAT));
    chk("rd5_data", rd, d_a5);
    last_rd = rd;

    // Dirty writeback then fill, new request driven the cycle after ready.
    access(1'b1, 28'h3, d3, lat, rd);
    access(1'b1, 28'h10, d10, lat, rd);
    chk("wr10_latency", 128'(lat), 128'(LAT));
    chk("rdata_held_over_wr", mem_rdata, last_rd);
    access(1'b0, 28'h3, '0, lat, rd);
    chk("fill_latency", 128'(lat), 128'(LAT));
    chk("fill_data", rd, d3);
    access(1'b0, 28'h10, '0, lat, rd);
    chk("rd10_data", rd, d10);

    access(1'b1, 28'h400, d4, lat, rd);
    access(1'b0, 28'h000, '0, lat, rd);
    chk("alias_data", rd, d4);

    access(1'b1, 28'h7, d7, lat, rd);
    mem_write = 1'b1;
    mem_addr  = 28'h7;
    mem_wdata = dx;
    repeat (4) @(posedge clk);
    @(negedge clk);
    proc_reset_n = 1'b0;
    #1;
    chk("midrst_ready", {127'd0, mem_ready}, '0);
    chk("midrst_rdata", mem_rdata, '0);
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b1;
    @(negedge clk);
    access(1'b0, 28'h7, '0, lat, rd);
    chk("midrst_discard", rd, d7);
    chk("perr_clean", {127'd0, proto_err}, '0);

    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 28'h5;
    pulses    = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    chk("both_no_accept", 128'(pulses), '0);
    chk("both_perr", {127'd0, proto_err}, {127'd0, PERR_EXP});
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("perr_sticky", {127'd0, proto_err}, {127'd0, PERR_EXP});
    access(1'b0, 28'h5, '0, lat, rd);
    chk("after_both_latency", 128'(lat), 128'(LAT));
    chk("after_both_data", rd, d_a5);
    proc_reset_n = 1'b0;
    #1;
    chk("perr_cleared", {127'd0, proto_err}, '0);
    @(negedge clk);
    proc_reset_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
